// File: rtl/cpu_pkg.sv
// Shared types for the CPU slice: boot loader state encoding and frame constants.
package cpu_pkg;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
      WRITE,
      CHK,
      DONE,
      ERR
   } boot_state_t;

   localparam int BOOT_HDR_BYTES  = 2;
   localparam int BOOT_WORD_BYTES = 4;

endpackage

// File: rtl/boot_word_asm.sv
// Big-endian word assembler: shifts payload bytes in MSB first, counts bytes
// per word and keeps the running XOR checksum of every payload byte.
module boot_word_asm
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic [7:0]  csum,
   output logic        word_full
);

   localparam logic [1:0] LAST_BYTE = 2'(BOOT_WORD_BYTES - 1);

   logic [23:0] shreg;
   logic [1:0]  byte_idx;

   // The completed word is exposed combinationally so it can be captured on
   // the same edge that accepts the final byte.
   assign word_next = {shreg, byte_in};
   assign word_full = shift_en && (byte_idx == LAST_BYTE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shreg    <= '0;
         byte_idx <= '0;
         csum     <= '0;
      end else if (clear) begin
         shreg    <= '0;
         byte_idx <= '0;
         csum     <= '0;
      end else if (shift_en) begin
         shreg    <= word_next[23:0];
         byte_idx <= byte_idx + 2'd1;
         csum     <= csum ^ byte_in;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader: header, payload words into memory, XOR checksum,
// then releases the CPU. Define BOOT_TIMEOUT_EN to abort on idle streams.
module boot_loader
   import cpu_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int          MAX_WORDS      = 256,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        cpu_run,
   output logic        done,
   output logic        error,
   output logic [15:0] word_cnt
);

   localparam logic [16:0] MAX_N  = 17'(MAX_WORDS);
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);

   boot_state_t state, state_d;

   logic [7:0]  hdr_hi;
   logic [15:0] n_words;
   logic [15:0] n_in;
   logic        xfer;
   logic        recv;
   logic        timeout;
   logic [31:0] word_next;
   logic [7:0]  csum;
   logic        word_full;

   assign recv = (state == HDR_HI) || (state == HDR_LO) ||
                 (state == DATA)   || (state == CHK);
   assign xfer = byte_valid && byte_ready;
   assign n_in = {hdr_hi, byte_data};

   boot_word_asm u_asm (
      .clock     (clock),
      .reset     (reset),
      .clear     (state == HDR_HI),
      .shift_en  (xfer && (state == DATA)),
      .byte_in   (byte_data),
      .word_next (word_next),
      .csum      (csum),
      .word_full (word_full)
   );

`ifdef BOOT_TIMEOUT_EN
   // HDR_HI is excluded so an idle link simply waits for a frame to start.
   logic [15:0] idle_cnt;
   logic        idle_run;

   assign idle_run = (state == HDR_LO) || (state == DATA) || (state == CHK);
   assign timeout  = idle_run && !xfer && (idle_cnt == TO_LIM);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         idle_cnt <= '0;
      else if (!idle_run || xfer)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 16'd1;
   end
`else
   logic unused_timeout;
   assign timeout        = 1'b0;
   assign unused_timeout = ^TO_LIM;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= HDR_HI;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         HDR_HI: if (xfer) state_d = HDR_LO;
         HDR_LO: begin
            if (xfer) begin
               if ({1'b0, n_in} > MAX_N)
                  state_d = ERR;
               else if (n_in == 16'd0)
                  state_d = CHK;
               else
                  state_d = DATA;
            end
         end
         DATA:   if (word_full) state_d = WRITE;
         WRITE:  state_d = ((word_cnt + 16'd1) == n_words) ? CHK : DATA;
         CHK: begin
            if (xfer)
               state_d = (byte_data == csum) ? DONE : ERR;
         end
         DONE:    state_d = DONE;
         ERR:     state_d = ERR;
         default: state_d = HDR_HI;
      endcase
      if (timeout)
         state_d = ERR;
   end

   // byte_ready is gated by reset so every output reads 0 while reset is held.
   always_comb begin
      byte_ready = reset && recv;
      mem_wr     = (state == WRITE);
      done       = (state == DONE);
      error      = (state == ERR);
      cpu_run    = (state == DONE);
   end

   // Address and data are captured with the final byte so they are stable for
   // the whole WRITE cycle and hold afterwards.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hdr_hi    <= '0;
         n_words   <= '0;
         word_cnt  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (state == HDR_HI && xfer)
            hdr_hi <= byte_data;
         if (state == HDR_LO && xfer)
            n_words <= n_in;
         if (word_full) begin
            mem_addr  <= ADDR_BASE + {14'd0, word_cnt, 2'b00};
            mem_wdata <= word_next;
         end
         if (state == WRITE)
            word_cnt <= word_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued by the stimulus
// and checked by an independent monitor on every mem_wr pulse.
module tb_boot_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        cpu_run;
   logic        done;
   logic        error;
   logic [15:0] word_cnt;

   boot_loader #(
      .ADDR_BASE      (32'h0000_0000),
      .MAX_WORDS      (256),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wr     (mem_wr),
      .cpu_run    (cpu_run),
      .done       (done),
      .error      (error),
      .word_cnt   (word_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] frm[$];
   int checks = 0;
   int failures = 0;
   int wr_pulses = 0;
   int stalls = 0;
   int base = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Called at a falling edge; the byte transfers on the next rising edge
   // where byte_ready is high. byte_valid stays high on return.
   task automatic send(input logic [7:0] b);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 20) begin
         @(negedge clock);
         n++;
         stalls++;
      end
      if (!byte_ready) begin
         checks++;
         failures++;
         $display("FAIL send_stuck: byte %h never accepted", b);
      end
      @(negedge clock);
   endtask

   task automatic send_frm();
      for (int i = 0; i < frm.size(); i++)
         send(frm[i]);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      byte_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   always @(negedge clock) begin
      if (reset && mem_wr) begin
         wr_pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", mem_addr, mon_e.addr);
            chk("wr_data", mem_wdata, mon_e.data);
         end
      end
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_mem_wr",     32'(mem_wr),     32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_error",      32'(error),      32'd0);
      chk("rst_cpu_run",    32'(cpu_run),    32'd0);
      chk("rst_word_cnt",   32'(word_cnt),   32'd0);
      chk("rst_mem_addr",   mem_addr,        32'd0);
      chk("rst_mem_wdata",  mem_wdata,       32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("ready_hdr_hi", 32'(byte_ready), 32'd1);

      // Good frame, byte_valid held high: payload XOR is 0x00.
      exp_wr(32'h0, 32'h1234_5678);
      exp_wr(32'h4, 32'h9ABC_DEF0);
      stalls = 0;
      base = wr_pulses;
      frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
      send_frm();
      chk("good_done",     32'(done),      32'd1);
      chk("good_cpu_run",  32'(cpu_run),   32'd1);
      chk("good_error",    32'(error),     32'd0);
      chk("good_word_cnt", 32'(word_cnt),  32'd2);
      chk("good_wr_count", 32'(wr_pulses - base), 32'd2);
      chk("good_stalls",   32'(stalls),    32'd2);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (3) @(negedge clock);
      chk("done_no_accept", 32'(byte_ready), 32'd0);
      chk("done_sticky",    32'(done),       32'd1);
      byte_valid = 1'b0;

      // Same payload, checksum 0xE8 does not match.
      pulse_reset();
      exp_wr(32'h0, 32'h1234_5678);
      exp_wr(32'h4, 32'h9ABC_DEF0);
      base = wr_pulses;
      frm[10] = 8'hE8;
      send_frm();
      chk("bad_error",    32'(error),    32'd1);
      chk("bad_done",     32'(done),     32'd0);
      chk("bad_cpu_run",  32'(cpu_run),  32'd0);
      chk("bad_word_cnt", 32'(word_cnt), 32'd2);
      chk("bad_wr_count", 32'(wr_pulses - base), 32'd2);
      chk("err_no_accept", 32'(byte_ready), 32'd0);

      // N = 257 exceeds MAX_WORDS.
      pulse_reset();
      base = wr_pulses;
      frm = '{8'h01, 8'h01};
      send_frm();
      chk("ovf_error", 32'(error), 32'd1);
      repeat (4) @(negedge clock);
      chk("ovf_no_wr", 32'(wr_pulses - base), 32'd0);

      // Empty image.
      pulse_reset();
      base = wr_pulses;
      frm = '{8'h00, 8'h00, 8'h00};
      send_frm();
      chk("empty_done",     32'(done),     32'd1);
      chk("empty_word_cnt", 32'(word_cnt), 32'd0);
      chk("empty_no_wr",    32'(wr_pulses - base), 32'd0);
      pulse_reset();
      frm = '{8'h00, 8'h00, 8'h01};
      send_frm();
      chk("empty_bad_error", 32'(error), 32'd1);

      // Reset after 6 payload bytes, then a full clean reload.
      pulse_reset();
      exp_wr(32'h0, 32'h1234_5678);
      frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      send_frm();
      reset = 1'b0;
      @(negedge clock);
      chk("abort_word_cnt", 32'(word_cnt), 32'd0);
      chk("abort_mem_addr", mem_addr,      32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_first_written", 32'(exp_q.size()), 32'd0);
      exp_wr(32'h0, 32'h1234_5678);
      exp_wr(32'h4, 32'h9ABC_DEF0);
      frm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
      send_frm();
      chk("reload_done",     32'(done),     32'd1);
      chk("reload_word_cnt", 32'(word_cnt), 32'd2);
      chk("reload_last_addr", mem_addr,     32'h4);

`ifdef BOOT_TIMEOUT_EN
      pulse_reset();
      frm = '{8'h00, 8'h01, 8'h12};
      send_frm();
      repeat (7) @(negedge clock);
      chk("idle7_no_error", 32'(error), 32'd0);
      @(negedge clock);
      chk("idle8_error", 32'(error), 32'd1);
`endif

      repeat (3) @(negedge clock);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
